dma_controller: RTL and testbench
=================================

Name: dma_controller

Overview:
- Block-copy engine behind the four DMA registers (SRC_L, SRC_U, DST, AMT) decoded by the memory map controller.
- The CPU programs the engine; writing AMT starts a transfer.
- Each word is fetched from the wide external source space over a req/ack handshake, then written into the 16-bit data bus (program RAM, sprite, tile or palette VRAM).
- dma_busy stalls the CPU and gives the bus to the engine for the duration of the transfer.

Parameters:
- SRC_WIDTH, 32, source address width; SRC_U supplies bits [SRC_WIDTH-1:16].
- ADDR_WIDTH, 16, destination bus address width.
- DATA_WIDTH, 16, word width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- dma_en  in  1  CPU access targets the DMA register block
- dma_mode  in  2  register select: 0=SRC_L, 1=SRC_U, 2=DST, 3=AMT
- memwrite  in  1  CPU write strobe
- writedata  in  DATA_WIDTH  CPU write data
- dma_rdata  out  DATA_WIDTH  register readback, registered
- src_addr  out  SRC_WIDTH  source word address
- src_req  out  1  source read request
- src_ack  in  1  source data valid; one-cycle pulse
- src_rdata  in  DATA_WIDTH  source data, sampled when src_ack=1
- dma_busy  out  1  transfer in progress; CPU stalled, bus owned by DMA
- dma_addr  out  ADDR_WIDTH  destination bus address
- dma_wdata  out  DATA_WIDTH  destination write data
- dma_we  out  1  destination write strobe, one cycle per word

Behaviour:
- Reset (rst=0 at posedge clk), valid at any time:
  - all registers cleared, state=IDLE;
  - dma_busy, src_req, dma_we = 0;
  - dma_addr, dma_wdata, src_addr, dma_rdata = 0;
  - a transfer in flight is aborted and no further writes are issued.
- Register writes (dma_en & memwrite & state==IDLE):
  - mode 0 → src[15:0];
  - mode 1 → src[SRC_WIDTH-1:16];
  - mode 2 → dst;
  - mode 3 → cnt, and starts a transfer if writedata != 0.
  - Any register write while busy is ignored.
- AMT=0 write: cnt=0, stays IDLE, dma_busy remains 0.
- Readback: dma_rdata updates one cycle after dma_en with the selected register. Mode 3 returns the remaining cnt; it reads 0 after completion.
- FSM:
  - IDLE→READ on start. dma_busy rises the cycle after the AMT write and stays 1 through the last write.
  - READ: src_req=1, src_addr=src. Stay in READ until src_ack. On ack, latch src_rdata into dma_wdata and go to WRITE.
  - WRITE: single cycle with dma_we=1, dma_addr=dst. Then src+=1, dst+=1, cnt-=1.
  - After WRITE: if the new cnt is 0, go to IDLE and drop dma_busy the same cycle; otherwise go to READ.
- Throughput: at best 2 cycles/word (ack in the first READ cycle). Each added ack wait cycle adds one cycle.
- Handshake: src_req is held continuously until ack and deasserted the cycle after ack. src_ack outside READ is ignored.
- Wrap-around:
  - dst wraps 0xFFFF→0x0000 (modulo 2^ADDR_WIDTH);
  - src wraps modulo 2^SRC_WIDTH;
  - no error is flagged in either case.
- cnt=0xFFFF is a legal maximal transfer of 65535 words.
- dma_addr is driven only while busy; the map controller muxes on dma_busy.

Decomposition:
- Shared package dma_pkg holds:
  - register-select constants DMA_SEL_SRC_L/SRC_U/DST/AMT (0..3);
  - state encoding ST_IDLE/ST_READ/ST_WRITE.
- The same register offsets are used by the memory map controller's DMA_REGS decode.
- No sub-module. A single FSM plus address counters is natural; the register file is inline.

Test Plan:
- Basic copy: SRC=0x0001_0000, DST=0x2400, AMT=4, source returns 0xA000+offset with ack after 1 cycle → dma_we at 0x2400..0x2403 with data 0xA000..0xA003. dma_busy is high for 8 cycles, then AMT reads 0.
- Zero length: AMT=0 → dma_busy never asserts, src_req stays 0, no dma_we.
- Ack latency: ack delayed 3 cycles per word, AMT=2 → src_req held for 3 cycles each time, exactly 2 writes, correct data.
- Wrap: DST=0xFFFE, SRC=0x0000_FFFF, AMT=3 → writes to 0xFFFE, 0xFFFF, 0x0000; src_addr steps 0x0000_FFFF→0x0001_0000→0x0001_0001.
- Busy-write ignore: write DST=0x1234 mid-transfer → destination sequence unchanged; DST reads back the incremented value after completion.
- Reset mid-operation: rst=0 during READ of word 2 of 5 → next cycle dma_busy=0, src_req=0, all registers 0, no further dma_we.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared DMA definitions: register offsets (also decoded by the memory map
// controller) and the engine's state encoding.
package dma_pkg;

  localparam logic [1:0] DMA_SEL_SRC_L = 2'd0;
  localparam logic [1:0] DMA_SEL_SRC_U = 2'd1;
  localparam logic [1:0] DMA_SEL_DST   = 2'd2;
  localparam logic [1:0] DMA_SEL_AMT   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } dma_state_e;

endpackage

// File: rtl/dma_controller.sv
// Block-copy engine: reads words from the wide source space over req/ack and
// writes them onto the 16-bit bus, stalling the CPU while busy.
module dma_controller
  import dma_pkg::*;
#(
  parameter int SRC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dma_en,
  input  logic [1:0]            dma_mode,
  input  logic                  memwrite,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic [SRC_WIDTH-1:0]  src_addr,
  output logic                  src_req,
  input  logic                  src_ack,
  input  logic [DATA_WIDTH-1:0] src_rdata,
  output logic                  dma_busy,
  output logic [ADDR_WIDTH-1:0] dma_addr,
  output logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_we
);

  localparam int SRC_HI_W = SRC_WIDTH - 16;

  dma_state_e            state_q, state_d;
  logic [SRC_WIDTH-1:0]  src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  reg_wr;

  // Register writes are only honoured while idle; the CPU cannot retarget a live transfer.
  assign reg_wr = dma_en & memwrite & (state_q == ST_IDLE);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    if (dma_en) begin
      case (dma_mode)
        DMA_SEL_SRC_L: rdata_d = DATA_WIDTH'(src_q[15:0]);
        DMA_SEL_SRC_U: rdata_d = DATA_WIDTH'(src_q[SRC_WIDTH-1:16]);
        DMA_SEL_DST:   rdata_d = DATA_WIDTH'(dst_q);
        DMA_SEL_AMT:   rdata_d = cnt_q;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (reg_wr) begin
          case (dma_mode)
            DMA_SEL_SRC_L: src_d[15:0]           = 16'(writedata);
            DMA_SEL_SRC_U: src_d[SRC_WIDTH-1:16] = SRC_HI_W'(writedata);
            DMA_SEL_DST:   dst_d                 = ADDR_WIDTH'(writedata);
            DMA_SEL_AMT: begin
              cnt_d = writedata;
              if (writedata != '0) state_d = ST_READ;
            end
          endcase
        end
      end
      ST_READ: begin
        if (src_ack) begin
          wdata_d = src_rdata;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Counters wrap silently; a zero remaining count ends the transfer.
        src_d   = src_q + SRC_WIDTH'(1);
        dst_d   = dst_q + ADDR_WIDTH'(1);
        cnt_d   = cnt_q - DATA_WIDTH'(1);
        state_d = (cnt_q == DATA_WIDTH'(1)) ? ST_IDLE : ST_READ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign dma_busy  = (state_q != ST_IDLE);
  assign src_req   = (state_q == ST_READ);
  assign src_addr  = src_req ? src_q : '0;
  assign dma_addr  = dma_busy ? dst_q : '0;
  assign dma_we    = (state_q == ST_WRITE);
  assign dma_wdata = wdata_q;
  assign dma_rdata = rdata_q;

endmodule

// File: tb/tb_dma_controller.sv
// Randomized bench for dma_controller: a responder models the source space and a
// transaction-level model predicts the write sequence, timing and readback.
module tb_dma_controller;
  import dma_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dma_en = 1'b0;
  logic [1:0]  dma_mode = 2'd0;
  logic        memwrite = 1'b0;
  logic [15:0] writedata = '0;
  logic [15:0] dma_rdata;
  logic [31:0] src_addr;
  logic        src_req;
  logic        src_ack = 1'b0;
  logic [15:0] src_rdata = '0;
  logic        dma_busy;
  logic [15:0] dma_addr;
  logic [15:0] dma_wdata;
  logic        dma_we;

  dma_controller dut (
    .clk       (clk),
    .rst       (rst),
    .dma_en    (dma_en),
    .dma_mode  (dma_mode),
    .memwrite  (memwrite),
    .writedata (writedata),
    .dma_rdata (dma_rdata),
    .src_addr  (src_addr),
    .src_req   (src_req),
    .src_ack   (src_ack),
    .src_rdata (src_rdata),
    .dma_busy  (dma_busy),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_we    (dma_we)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source responder and bus monitor state
  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [31:0] ack_addr_q[$];
  int          lat_log[$];
  int          busy_cycles = 0;
  int          bad_outside = 0;
  int          req_cnt = 0;
  int          cur_lat = 1;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [15:0] salt = '0;
  logic [31:0] src_origin = '0;

  always begin
    @(negedge clk);
    if (dma_we) begin
      wr_addr_q.push_back(dma_addr);
      wr_data_q.push_back(dma_wdata);
    end
    if (dma_busy) busy_cycles++;
    if (!dma_busy && (src_req || dma_we)) bad_outside++;
    if (src_req) begin
      req_cnt++;
      if (req_cnt >= cur_lat) begin
        src_ack   = 1'b1;
        src_rdata = salt + 16'(src_addr - src_origin);
        ack_addr_q.push_back(src_addr);
        lat_log.push_back(req_cnt);
        req_cnt   = 0;
        cur_lat   = $urandom_range(lat_max, lat_min);
      end else begin
        src_ack   = 1'b0;
        src_rdata = 16'($urandom);
      end
    end else begin
      // Stray acks outside a read must be ignored by the engine.
      req_cnt   = 0;
      src_ack   = ($urandom_range(3, 0) == 0);
      src_rdata = 16'hDEAD;
    end
  end

  task automatic cpu_write(input logic [1:0] sel, input logic [15:0] d);
    @(posedge clk); #1;
    dma_en = 1'b1; memwrite = 1'b1; dma_mode = sel; writedata = d;
    @(posedge clk); #1;
    dma_en = 1'b0; memwrite = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] sel, output logic [15:0] d);
    @(posedge clk); #1;
    dma_en = 1'b1; memwrite = 1'b0; dma_mode = sel;
    @(posedge clk); #1;
    dma_en = 1'b0;
    d = dma_rdata;
  endtask

  task automatic program_and_start(input logic [31:0] src, input logic [15:0] dst,
                                   input logic [15:0] cnt, input int lmin, input int lmax,
                                   input logic [15:0] s);
    lat_min = lmin; lat_max = lmax; salt = s; src_origin = src;
    cur_lat = $urandom_range(lmax, lmin);
    cpu_write(DMA_SEL_SRC_L, src[15:0]);
    cpu_write(DMA_SEL_SRC_U, src[31:16]);
    cpu_write(DMA_SEL_DST, dst);
    wr_addr_q.delete(); wr_data_q.delete(); ack_addr_q.delete(); lat_log.delete();
    busy_cycles = 0; bad_outside = 0;
    cpu_write(DMA_SEL_AMT, cnt);
  endtask

  task automatic run_transfer(input string nm, input logic [31:0] src, input logic [15:0] dst,
                              input logic [15:0] cnt, input int lmin, input int lmax,
                              input logic [15:0] s, input bit poke);
    int          budget;
    int          exp_busy;
    logic [15:0] rd;
    logic [31:0] src_end;
    program_and_start(src, dst, cnt, lmin, lmax, s);
    check({nm, "/busy_after_amt"}, 32'(dma_busy), 32'(cnt != 0));
    if (poke) begin
      cpu_write(DMA_SEL_DST, 16'h1234);
      cpu_write(DMA_SEL_SRC_L, 16'h5555);
      cpu_write(DMA_SEL_AMT, 16'h0001);
    end
    budget = int'(cnt) * (lmax + 1) + 20;
    while (dma_busy && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check({nm, "/done_in_time"}, 32'(dma_busy), 32'd0);
    @(posedge clk); #1;

    check({nm, "/nwrites"}, wr_addr_q.size(), 32'(cnt));
    for (int i = 0; i < int'(cnt) && i < wr_addr_q.size(); i++) begin
      check({nm, "/waddr"}, 32'(wr_addr_q[i]), 32'(16'(dst + 16'(i))));
      check({nm, "/wdata"}, 32'(wr_data_q[i]), 32'(16'(s + 16'(i))));
    end
    for (int i = 0; i < int'(cnt) && i < ack_addr_q.size(); i++)
      check({nm, "/src_addr"}, ack_addr_q[i], src + 32'(i));
    exp_busy = 0;
    foreach (lat_log[i]) exp_busy += lat_log[i] + 1;
    check({nm, "/busy_cycles"}, busy_cycles, exp_busy);
    check({nm, "/outside_busy"}, bad_outside, 0);

    src_end = src + 32'(cnt);
    cpu_read(DMA_SEL_AMT, rd);   check({nm, "/rd_amt"}, 32'(rd), 32'd0);
    cpu_read(DMA_SEL_DST, rd);   check({nm, "/rd_dst"}, 32'(rd), 32'(16'(dst + cnt)));
    cpu_read(DMA_SEL_SRC_L, rd); check({nm, "/rd_src_l"}, 32'(rd), 32'(src_end[15:0]));
    cpu_read(DMA_SEL_SRC_U, rd); check({nm, "/rd_src_u"}, 32'(rd), 32'(src_end[31:16]));
  endtask

  initial begin
    logic [15:0] rd;
    int          budget;
    int          cnt;

    repeat (3) @(posedge clk);
    #1;
    check("rst/busy", 32'(dma_busy), 0);
    check("rst/src_req", 32'(src_req), 0);
    check("rst/we", 32'(dma_we), 0);
    check("rst/rdata", 32'(dma_rdata), 0);
    rst = 1'b1;

    run_transfer("basic", 32'h0001_0000, 16'h2400, 16'd4, 1, 1, 16'hA000, 1'b0);
    check("basic/busy8", busy_cycles, 8);

    run_transfer("zero", 32'h0007_1234, 16'h3000, 16'd0, 1, 1, 16'h0000, 1'b0);

    run_transfer("latency", 32'h0002_0040, 16'h0100, 16'd2, 3, 3, 16'h5A00, 1'b0);
    check("latency/busy8", busy_cycles, 8);

    run_transfer("wrap", 32'h0000_FFFF, 16'hFFFE, 16'd3, 1, 2, 16'h1100, 1'b0);

    run_transfer("busy_ignore", 32'h0003_0000, 16'h0800, 16'd4, 2, 2, 16'hC000, 1'b1);

    for (int t = 0; t < 12; t++) begin
      logic [15:0] d;
      d   = (t % 3 == 0) ? 16'hFFFC + 16'($urandom_range(3, 0)) : 16'($urandom);
      cnt = $urandom_range(6, 0);
      run_transfer("rand", $urandom, d, 16'(cnt), 1, $urandom_range(4, 1), 16'($urandom), 1'b0);
    end

    // Reset while reading word 2 of 5
    program_and_start(32'h0004_0010, 16'h4000, 16'd5, 2, 2, 16'h7700);
    budget = 50;
    while (!(wr_addr_q.size() == 1 && src_req) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("rstmid/reached_word2", 32'(wr_addr_q.size() == 1 && src_req), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("rstmid/busy", 32'(dma_busy), 0);
    check("rstmid/src_req", 32'(src_req), 0);
    check("rstmid/we", 32'(dma_we), 0);
    check("rstmid/src_addr", src_addr, 0);
    check("rstmid/dma_addr", 32'(dma_addr), 0);
    check("rstmid/wdata", 32'(dma_wdata), 0);
    check("rstmid/rdata", 32'(dma_rdata), 0);
    repeat (10) @(posedge clk);
    #1;
    check("rstmid/nwrites", wr_addr_q.size(), 1);
    cpu_read(DMA_SEL_SRC_L, rd); check("rstmid/rd_src_l", 32'(rd), 0);
    cpu_read(DMA_SEL_SRC_U, rd); check("rstmid/rd_src_u", 32'(rd), 0);
    cpu_read(DMA_SEL_DST, rd);   check("rstmid/rd_dst", 32'(rd), 0);
    cpu_read(DMA_SEL_AMT, rd);   check("rstmid/rd_amt", 32'(rd), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
